// File: rtl/ch_response_checker.sv
// ch_response_checker: read-side compare for the checkerboard SRAM BIST.
// It delays issued reads by the SRAM latency, compares them with the returned words and accumulates the results.
module ch_response_checker #(
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 4,
  parameter int READ_LATENCY    = 1,
  parameter int FAIL_CNT_WIDTH  = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cmp_en,
  input  logic [SRAM_ADDR_WIDTH-1:0] cmp_addr,
  input  logic                       cmp_bit,
  input  logic                       last,
  input  logic [DATA_WIDTH-1:0]      sram_dout,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [FAIL_CNT_WIDTH-1:0]  fail_count,
  output logic [SRAM_ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0]      first_fail_data
);
  typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] dcnt;
  logic [READ_LATENCY-1:0] vld, bit_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0] exp_w;
  logic clr, mism;
  always_comb begin
    state_nx = state;
    clr = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nx = CHECK;
        clr = 1'b1;
      end
      CHECK: if (last) state_nx = DRAIN;
      DRAIN: if (dcnt == 3'(READ_LATENCY - 1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state == CHECK || state == DRAIN;
  assign done = state == DONE;
  assign pass = done && fail_count == '0;
  // Expected word alternates from the MSB, starting with the pattern bit.
  always_comb begin
    exp_w = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      exp_w[i] = bit_d[READ_LATENCY-1] ^ 1'((DATA_WIDTH - 1 - i) % 2);
  end
  assign mism = busy && vld[READ_LATENCY-1] && sram_dout != exp_w;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dcnt <= '0;
    end else begin
      state <= state_nx;
      dcnt <= state == DRAIN ? dcnt + 3'd1 : 3'd0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      bit_d <= '0;
      for (int i = 0; i < READ_LATENCY; i++) addr_d[i] <= '0;
    end else if (busy) begin
      vld[0] <= cmp_en && state == CHECK;
      bit_d[0] <= cmp_bit;
      addr_d[0] <= cmp_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        bit_d[i] <= bit_d[i-1];
        addr_d[i] <= addr_d[i-1];
      end
    end else begin
      vld <= '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      fail <= 1'b0;
      fail_count <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (mism) begin
      if (fail_count != '1) fail_count <= fail_count + 1'b1;
      if (!fail) begin
        fail <= 1'b1;
        first_fail_addr <= addr_d[READ_LATENCY-1];
        first_fail_data <= sram_dout;
      end
    end
  end
endmodule

// File: tb/tb_ch_response_checker.sv
// tb_ch_response_checker: randomized bench with a transaction-level reference model.
// Two instances run side by side: default parameters, and READ_LATENCY=3 with a 4-bit counter.
module tb_ch_response_checker;
  logic clk = 0, rst = 1, start = 0, cmp_en = 0, cmp_bit = 0, last = 0;
  logic [7:0] cmp_addr = 0;
  logic [3:0] wp [3];
  logic [3:0] fm [256];
  logic b1, dn1, p1, f1, b3, dn3, p3, f3;
  logic [8:0] fc1;
  logic [3:0] fc3, fd1, fd3;
  logic [7:0] fa1, fa3;
  int tests = 0, fails = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  ch_response_checker d1 (.clk(clk), .rst(rst), .start(start), .cmp_en(cmp_en), .cmp_addr(cmp_addr),
    .cmp_bit(cmp_bit), .last(last), .sram_dout(wp[0]), .busy(b1), .done(dn1), .pass(p1), .fail(f1),
    .fail_count(fc1), .first_fail_addr(fa1), .first_fail_data(fd1));
  ch_response_checker #(.READ_LATENCY(3), .FAIL_CNT_WIDTH(4)) d3 (.clk(clk), .rst(rst), .start(start),
    .cmp_en(cmp_en), .cmp_addr(cmp_addr), .cmp_bit(cmp_bit), .last(last), .sram_dout(wp[2]), .busy(b3),
    .done(dn3), .pass(p3), .fail(f3), .fail_count(fc3), .first_fail_addr(fa3), .first_fail_data(fd3));

  function automatic logic [3:0] pat(input logic b);
    return b ? 4'b1010 : 4'b0101;
  endfunction

  // SRAM model: returns the pattern word with the fault mask applied, garbage when no read was issued.
  always @(posedge clk) begin
    wp[0] <= cmp_en ? pat(cmp_bit) ^ fm[cmp_addr] : 4'($urandom);
    wp[1] <= wp[0];
    wp[2] <= wp[1];
  end

  typedef struct {int k; longint due; logic mm; logic [7:0] a; logic [3:0] d;} item_t;
  localparam int LAT [2] = '{1, 3};
  localparam int MAXC [2] = '{511, 15};
  int mc [2];
  logic mf [2], macc [2];
  logic [7:0] ma [2];
  logic [3:0] md [2];
  longint dat [2] = '{-1, -1};
  longint n = 0;
  item_t q[$], nq[$];

  function automatic bit mbusy(input int k);
    return macc[k] || (dat[k] >= 0 && n < dat[k]);
  endfunction
  function automatic bit edone(input int k);
    return !macc[k] && dat[k] >= 0 && n >= dat[k];
  endfunction

  // Each accepted read becomes visible LAT+1 cycles later; done appears LAT+1 cycles after last.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mc[k] = 0; mf[k] = 0; ma[k] = 0; md[k] = 0; macc[k] = 0; dat[k] = -1;
      end
      q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!mbusy(k) && start) begin
          mc[k] = 0; mf[k] = 0; ma[k] = 0; md[k] = 0; macc[k] = 1; dat[k] = -1;
        end else if (macc[k]) begin
          if (cmp_en) q.push_back('{k, n + 1 + LAT[k], fm[cmp_addr] != 0, cmp_addr, pat(cmp_bit) ^ fm[cmp_addr]});
          if (last) begin
            macc[k] = 0;
            dat[k] = n + 1 + LAT[k];
          end
        end
      end
      n++;
      nq.delete();
      foreach (q[j]) begin
        if (q[j].due == n) begin
          if (q[j].mm) begin
            if (!mf[q[j].k]) begin
              mf[q[j].k] = 1; ma[q[j].k] = q[j].a; md[q[j].k] = q[j].d;
            end
            if (mc[q[j].k] < MAXC[q[j].k]) mc[q[j].k]++;
          end
        end else nq.push_back(q[j]);
      end
      q = nq;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("busy1", b1, mbusy(0)); chk("done1", dn1, edone(0)); chk("pass1", p1, edone(0) && mc[0] == 0);
    chk("fail1", f1, mf[0]); chk("cnt1", fc1, mc[0]); chk("addr1", fa1, ma[0]); chk("data1", fd1, md[0]);
    chk("busy3", b3, mbusy(1)); chk("done3", dn3, edone(1)); chk("pass3", p3, edone(1) && mc[1] == 0);
    chk("fail3", f3, mf[1]); chk("cnt3", fc3, mc[1]); chk("addr3", fa3, ma[1]); chk("data3", fd3, md[1]);
  end

  task automatic cyc_(input logic s, input logic e, input logic [7:0] a, input logic b, input logic l);
    @(negedge clk);
    start = s; cmp_en = e; cmp_addr = a; cmp_bit = b; last = l;
  endtask

  task automatic sweep(input int cnt, input int gap, input bit rs, input bit inv);
    logic [7:0] ad;
    cyc_(1, 0, 0, 0, 0);
    cyc_(0, 0, 0, 0, 0);
    chk("restart_fail1", f1, 0);
    chk("restart_busy1", b1, 1);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, gap)) cyc_(rs && $urandom_range(0, 3) == 0, 0, 8'($urandom), 0, 0);
      ad = 8'(i);
      cyc_(rs && $urandom_range(0, 3) == 0, 1, ad, ad[0] ^ inv, i == cnt - 1);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc_(0, 1'($urandom), 8'($urandom), 1'($urandom), 0);
      chk("done1_lat", dn1, k >= 2);
      chk("done3_lat", dn3, k >= 4);
    end
  endtask

  initial begin
    logic [7:0] ra;
    for (int i = 0; i < 256; i++) fm[i] = 0;
    #1 rst = 0;
    chk_on = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", b1, 0); chk("rst_done", dn1, 0); chk("rst_cnt", fc1, 0);
    rst = 1;
    sweep(256, 0, 0, 0);
    chk("clean_pass1", p1, 1); chk("clean_cnt1", fc1, 0); chk("clean_pass3", p3, 1);
    fm[8'h37] = 4'b0001;
    sweep(256, 0, 0, 1);
    chk("stuck_fail", f1, 1); chk("stuck_cnt", fc1, 1); chk("stuck_addr", fa1, 8'h37);
    chk("stuck_data", fd1, 4'b0100); chk("stuck_pass", p1, 0);
    fm[8'h37] = 0; fm[8'h05] = 4'b1000; fm[8'h80] = 4'b0011; fm[8'hFF] = 4'b0110;
    sweep(256, 0, 0, 0);
    chk("multi_cnt1", fc1, 3); chk("multi_addr1", fa1, 8'h05); chk("multi_data1", fd1, 4'b0010);
    chk("multi_cnt3", fc3, 3); chk("multi_addr3", fa3, 8'h05);
    for (int i = 0; i < 256; i++) fm[i] = 0;
    repeat (6) begin
      ra = 8'($urandom);
      fm[ra] = 4'($urandom_range(1, 15));
    end
    sweep(256, 3, 1, 0);
    chk("gaps_done3", dn3, 1);
    for (int i = 0; i < 256; i++) fm[i] = 4'b1111;
    sweep(520, 0, 0, 0);
    chk("sat_cnt1", fc1, 511); chk("sat_cnt3", fc3, 15); chk("sat_addr1", fa1, 0);
    chk("sat_data1", fd1, 4'b1010);
    cyc_(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc_(0, 1, 8'(i), 1'(i), 0);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("mid_busy1", b1, 0); chk("mid_fail1", f1, 0); chk("mid_cnt1", fc1, 0); chk("mid_addr1", fa1, 0);
    chk("mid_data1", fd1, 0); chk("mid_busy3", b3, 0); chk("mid_cnt3", fc3, 0); chk("mid_done3", dn3, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 256; i++) fm[i] = 0;
    sweep(256, 1, 1, 0);
    chk("after_rst_pass1", p1, 1); chk("after_rst_pass3", p3, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ch_response_checker.md
Name: ch_response_checker

Overview:
- Read-side response analyzer for the checkerboard BIST of the 256x4 SRAM.
- The checkerboard counter issues addresses and the expected pattern bit for each read. This block delays those by the SRAM read latency and compares them against the returned SRAM data word.
- It counts mismatches, captures the first failing address and data, and reports pass/fail once the sweep ends.

Parameters:
- SRAM_ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 4, SRAM data word width.
- READ_LATENCY, 1, cycles from read strobe to valid sram_dout (legal range 1-4).
- FAIL_CNT_WIDTH, 9, mismatch counter width (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a check pass and clears previous results.
- cmp_en  input  1  read strobe: the SRAM read for cmp_addr is issued this cycle.
- cmp_addr  input  SRAM_ADDR_WIDTH  address of the read being issued.
- cmp_bit  input  1  checkerboard pattern bit for that address.
- last  input  1  sweep complete (counter carry-out); sampled only in CHECK.
- sram_dout  input  DATA_WIDTH  SRAM read data, valid READ_LATENCY cycles after cmp_en.
- busy  output  1  high in CHECK and DRAIN.
- done  output  1  high in DONE.
- pass  output  1  done and fail_count==0.
- fail  output  1  sticky: set on the first mismatch of the pass.
- fail_count  output  FAIL_CNT_WIDTH  number of mismatching reads, saturating at all-ones.
- first_fail_addr  output  SRAM_ADDR_WIDTH  address of the first mismatch.
- first_fail_data  output  DATA_WIDTH  sram_dout captured at the first mismatch.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all pipeline registers clear.
  - busy=done=pass=fail=0; fail_count=0; first_fail_addr=0; first_fail_data=0.
  - Reset asserted mid-pass aborts the pass immediately; no partial results are retained.
- Expected word:
  - cmp_bit=1 gives alternating bits starting with 1 from the MSB (4'b1010 for DATA_WIDTH=4).
  - cmp_bit=0 gives the bitwise inverse (4'b0101).
- Delay pipeline:
  - cmp_en, cmp_addr and cmp_bit are delayed by a READ_LATENCY-deep shift register.
  - The pipeline shifts every cycle in CHECK and DRAIN.
  - In IDLE and DONE the pipeline's valid bits are forced to 0.
- Compare:
  - Active when the delayed valid bit is 1.
  - Mismatch = (sram_dout != expected word).
  - Results register on the next clock edge, so outputs are available READ_LATENCY+1 cycles after cmp_en.
- On a mismatch:
  - fail_count increments; it saturates and never wraps.
  - If fail was 0: set fail, and capture the delayed address into first_fail_addr and sram_dout into first_fail_data.
  - Later mismatches do not overwrite the captured address or data.
- FSM:
  - IDLE: start -> CHECK. Results clear on entry.
  - CHECK: cmp_en is accepted. When last=1 -> DRAIN. A cmp_en in the same cycle as last is still checked.
  - DRAIN: runs exactly READ_LATENCY cycles, completing in-flight compares. cmp_en is ignored. Then -> DONE.
  - DONE: results are held stable. start -> CHECK with results cleared in that same edge.
- start handling:
  - start in CHECK or DRAIN is ignored.
  - start and last together in CHECK: last wins.
- cmp_en outside CHECK is ignored; nothing is loaded into the pipeline.
- pass is combinational from state==DONE and fail_count==0; it is 0 in all other states.

Test Plan:
- Clean sweep, READ_LATENCY=1:
  - Stimulus: start; 256 reads at addr 0..255 with cmp_bit=addr[0]; model returns the matching word each time; last with the final read.
  - Required: done rises 2 cycles after last; pass=1; fail_count=0.
- Single stuck bit:
  - Stimulus: model forces sram_dout bit0=0 at addr 0x37 (expected 4'b0101).
  - Required: fail=1; fail_count=1; first_fail_addr=0x37; first_fail_data=4'b0100; pass=0.
- Multiple faults:
  - Stimulus: mismatches at 0x05, 0x80 and 0xFF.
  - Required: fail_count=3; first_fail_addr stays 0x05.
- Latency and gaps, READ_LATENCY=3:
  - Stimulus: random gaps between cmp_en pulses; final read coincides with last.
  - Required: the final read is still compared; DRAIN lasts 3 cycles; then done=1.
- Saturation, FAIL_CNT_WIDTH=4:
  - Stimulus: 20 mismatching reads.
  - Required: fail_count holds at 15.
- Reset and restart:
  - Stimulus: assert rst at read 100 of a pass.
  - Required: all outputs 0 immediately; a new start and clean sweep gives pass=1.
  - Also: a start during CHECK is ignored, and a start in DONE clears the previous fail.
